// File: rtl/life_sequencer_pkg.sv
// life_pkg
// Shared definitions for the Game-of-Life run/pause/step sequencer.
// Contents:
//   GRID_W        - width of the 8x8 grid bus (one bit per cell, bit = row*8+col)
//   DEFAULT_GEN_W - default generation counter width
//   DEFAULT_DIV_W - default rate divider width
//   life_state_t  - sequencer FSM state encoding (3 bits, visible on the state output)
package life_pkg;

  localparam int GRID_W        = 64;
  localparam int DEFAULT_GEN_W = 16;
  localparam int DEFAULT_DIV_W = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADING = 3'd1,
    PAUSED  = 3'd2,
    RUNNING = 3'd3,
    HALTED  = 3'd4
  } life_state_t;

endpackage

// File: rtl/life_sequencer_if.sv
// life_sequencer_if
// Bundles the control, datapath and status signals of the sequencer.
// Modports:
//   master - control source / datapath side: drives seed, load, run, step,
//            halt_en, rate, evo_next; observes evo_in and all status.
//   slave  - the sequencer: consumes the controls and evo_next; drives
//            evo_in, grid, generation, state, evolved, stable, extinct.
interface life_sequencer_if
  import life_pkg::*;
#(
  parameter int GEN_W = DEFAULT_GEN_W,
  parameter int DIV_W = DEFAULT_DIV_W
) ();

  logic [GRID_W-1:0] seed;
  logic              load;
  logic              run;
  logic              step;
  logic              halt_en;
  logic [DIV_W-1:0]  rate;
  logic [GRID_W-1:0] evo_in;
  logic [GRID_W-1:0] evo_next;
  logic [GRID_W-1:0] grid;
  logic [GEN_W-1:0]  generation;
  life_state_t       state;
  logic              evolved;
  logic              stable;
  logic              extinct;

  modport master (
    output seed, load, run, step, halt_en, rate, evo_next,
    input  evo_in, grid, generation, state, evolved, stable, extinct
  );

  modport slave (
    input  seed, load, run, step, halt_en, rate, evo_next,
    output evo_in, grid, generation, state, evolved, stable, extinct
  );

endinterface

// File: rtl/life_sequencer_rate_divider.sv
// rate_divider
// Free-running evolve-rate counter for the sequencer.
// Ports:
//   clk, reset - clock and synchronous active-low reset
//   clear      - force the count back to zero (wins over enable)
//   enable     - count this cycle
//   rate       - tick threshold; a tick fires every rate+1 enabled cycles
//   tick       - high while enabled and count >= rate
module rate_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Using >= rather than == means lowering rate below the current count
  // fires on the very next enabled cycle instead of wrapping the counter.
  assign tick = enable && (count >= rate);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (tick) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// life_sequencer
// Run/pause/step sequencer that owns the 8x8 Game-of-Life grid register and
// schedules evolves of the external combinational datapath.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous active-low reset
//   bus   - life_sequencer_if.slave: seed/load/run/step/halt_en/rate controls,
//           evo_in/evo_next datapath loop, grid/generation/state/evolved/
//           stable/extinct status
module life_sequencer
  import life_pkg::*;
#(
  parameter int GEN_W = DEFAULT_GEN_W,
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input logic             clk,
  input logic             reset,
  life_sequencer_if.slave bus
);

  life_state_t       state, state_next;
  logic [GRID_W-1:0] grid;
  logic [GEN_W-1:0]  generation;
  logic              evolved, stable, extinct;
  logic              step_q, step_edge;
  logic              do_evolve, halt_hit;
  logic              div_clear, div_enable, div_tick;

  assign step_edge = bus.step && !step_q;

  // A halt condition is either an all-zero result or a nonzero result
  // identical to the grid it came from.
  assign halt_hit = (bus.evo_next == '0) || (bus.evo_next == grid);

  // The divider only counts while genuinely running; dropping run holds it.
  // It is cleared on every load and on the PAUSED->RUNNING transition so the
  // first evolve lands rate+1 clocks after RUNNING is entered.
  assign div_enable = !bus.load && (state == RUNNING) && bus.run;
  assign div_clear  = bus.load || ((state == PAUSED) && !step_edge && bus.run);

  rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_enable),
    .rate   (bus.rate),
    .tick   (div_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and evolve decision. Load beats everything, then a step edge
  // (only honoured in PAUSED), then run. Any evolve that trips a halt
  // condition with halt_en set diverts to HALTED.
  always_comb begin
    state_next = state;
    do_evolve  = 1'b0;
    if (bus.load) begin
      state_next = LOADING;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        LOADING: state_next = bus.run ? RUNNING : PAUSED;
        PAUSED: begin
          if (step_edge)    do_evolve  = 1'b1;
          else if (bus.run) state_next = RUNNING;
        end
        RUNNING: begin
          if (!bus.run)      state_next = PAUSED;
          else if (div_tick) do_evolve  = 1'b1;
        end
        HALTED:  state_next = HALTED;
        default: state_next = IDLE;
      endcase
      if (do_evolve && bus.halt_en && halt_hit) state_next = HALTED;
    end
  end

  // Grid, generation and flag registers. Flags are sticky between loads;
  // extinction clears stable because an empty grid is not a still life.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grid       <= '0;
      generation <= '0;
      evolved    <= 1'b0;
      stable     <= 1'b0;
      extinct    <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      step_q  <= bus.step;
      evolved <= do_evolve;
      if (bus.load) begin
        grid       <= bus.seed;
        generation <= '0;
        stable     <= 1'b0;
        extinct    <= 1'b0;
      end else if (do_evolve) begin
        grid <= bus.evo_next;
        if (generation != '1) generation <= generation + 1'b1;
        if (bus.evo_next == '0) begin
          extinct <= 1'b1;
          stable  <= 1'b0;
        end else if (bus.evo_next == grid) begin
          stable <= 1'b1;
        end
      end
    end
  end

  assign bus.evo_in     = grid;
  assign bus.grid       = grid;
  assign bus.generation = generation;
  assign bus.state      = state;
  assign bus.evolved    = evolved;
  assign bus.stable     = stable;
  assign bus.extinct    = extinct;

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer
// Directed bench for life_sequencer. Models the external datapath as a
// toroidal 8x8 Game-of-Life step and checks hand-computed grids, counters,
// flags and states after each clock.
module tb_life_sequencer;
  import life_pkg::*;

  localparam logic [63:0] BLINK_A = 64'h0000_0000_0000_0007;
  localparam logic [63:0] BLINK_B = 64'h0200_0000_0000_0202;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   pulses;

  life_sequencer_if #(.GEN_W(16), .DIV_W(24)) bus ();

  life_sequencer #(.GEN_W(16), .DIV_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Torus-wrapped Game-of-Life step standing in for the external datapath
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0) || (dc != 0))
              cnt += g[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)] ? 1 : 0;
        n[r*8 + c] = (cnt == 3) || ((cnt == 2) && g[r*8 + c]);
      end
    end
    return n;
  endfunction

  assign bus.evo_next = life_next(bus.evo_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.seed = '0; bus.load = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    bus.halt_en = 1'b0; bus.rate = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_state", 64'(bus.state), 64'(IDLE));
    checkOutput("rst_grid", bus.grid, 64'h0);
    checkOutput("rst_evo_in", bus.evo_in, 64'h0);
    checkOutput("rst_gen", 64'(bus.generation), 64'd0);
    checkOutput("rst_flags", {61'd0, bus.evolved, bus.stable, bus.extinct}, 64'd0);
    reset = 1'b1;

    // IDLE ignores run and step
    bus.run = 1'b1; bus.step = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("idle_state", 64'(bus.state), 64'(IDLE));
    checkOutput("idle_grid", bus.grid, 64'h0);
    bus.run = 1'b0; bus.step = 1'b0;

    // Blinker at rate 0: one evolve per clock, alternating phases
    bus.seed = BLINK_A; bus.load = 1'b1; bus.halt_en = 1'b1; bus.rate = '0;
    applyStimulus();
    checkOutput("load_state", 64'(bus.state), 64'(LOADING));
    checkOutput("load_grid", bus.grid, BLINK_A);
    bus.load = 1'b0; bus.run = 1'b1;
    applyStimulus();
    checkOutput("run_enter", 64'(bus.state), 64'(RUNNING));
    checkOutput("run_enter_gen", 64'(bus.generation), 64'd0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus();
      checkOutput("blink_grid", bus.grid, (i % 2 == 1) ? BLINK_B : BLINK_A);
      checkOutput("blink_gen", 64'(bus.generation), 64'(i));
      checkOutput("blink_evolved", 64'(bus.evolved), 64'd1);
      checkOutput("blink_stable", 64'(bus.stable), 64'd0);
    end

    // Rate 3: pulses every 4 clocks, run drop freezes generation
    bus.run = 1'b0;
    applyStimulus();
    checkOutput("pause_state", 64'(bus.state), 64'(PAUSED));
    checkOutput("pause_gen", 64'(bus.generation), 64'd6);
    bus.rate = 24'd3; bus.run = 1'b1;
    applyStimulus();
    checkOutput("rate_enter", 64'(bus.state), 64'(RUNNING));
    for (int k = 1; k <= 8; k++) begin
      applyStimulus();
      checkOutput("rate_evolved", 64'(bus.evolved), (k % 4 == 0) ? 64'd1 : 64'd0);
      checkOutput("rate_gen", 64'(bus.generation), 64'(6 + k / 4));
    end
    bus.run = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("hold_state", 64'(bus.state), 64'(PAUSED));
    checkOutput("hold_gen", 64'(bus.generation), 64'd8);
    checkOutput("hold_grid", bus.grid, BLINK_A);

    // Held step gives exactly one evolve
    bus.step = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      if (bus.evolved) pulses++;
    end
    checkOutput("step_pulses", 64'(pulses), 64'd1);
    checkOutput("step_gen", 64'(bus.generation), 64'd9);
    checkOutput("step_grid", bus.grid, BLINK_B);
    checkOutput("step_state", 64'(bus.state), 64'(PAUSED));
    bus.step = 1'b0;
    applyStimulus();

    // Still life halts after its first evolve
    bus.seed = BLOCK; bus.load = 1'b1; bus.halt_en = 1'b1; bus.rate = '0;
    applyStimulus();
    bus.load = 1'b0; bus.run = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("still_stable", 64'(bus.stable), 64'd1);
    checkOutput("still_state", 64'(bus.state), 64'(HALTED));
    checkOutput("still_gen", 64'(bus.generation), 64'd1);
    checkOutput("still_extinct", 64'(bus.extinct), 64'd0);
    for (int k = 0; k < 4; k++) begin
      bus.step = ~bus.step;
      applyStimulus();
    end
    bus.step = 1'b0;
    checkOutput("halt_gen", 64'(bus.generation), 64'd1);
    checkOutput("halt_state", 64'(bus.state), 64'(HALTED));
    checkOutput("halt_grid", bus.grid, BLOCK);

    // Single cell dies out and halts
    bus.seed = 64'h1; bus.load = 1'b1;
    applyStimulus();
    checkOutput("ext_load_stable", 64'(bus.stable), 64'd0);
    bus.load = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("ext_grid", bus.grid, 64'h0);
    checkOutput("ext_flag", 64'(bus.extinct), 64'd1);
    checkOutput("ext_state", 64'(bus.state), 64'(HALTED));

    // Empty seed with halting disabled keeps running
    bus.seed = 64'h0; bus.load = 1'b1; bus.halt_en = 1'b0;
    applyStimulus();
    checkOutput("reload_flags", {62'd0, bus.stable, bus.extinct}, 64'd0);
    bus.load = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("nohalt_extinct", 64'(bus.extinct), 64'd1);
    checkOutput("nohalt_state", 64'(bus.state), 64'(RUNNING));
    applyStimulus();
    checkOutput("nohalt_gen", 64'(bus.generation), 64'd2);

    // Load beats a pending divider tick
    bus.seed = BLINK_A; bus.load = 1'b1;
    applyStimulus();
    checkOutput("loadwin_gen", 64'(bus.generation), 64'd0);
    checkOutput("loadwin_evolved", 64'(bus.evolved), 64'd0);
    bus.load = 1'b0;
    applyStimulus();
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("mid_gen", 64'(bus.generation), 64'd5);
    checkOutput("mid_grid", bus.grid, BLINK_B);

    // Reset mid-run, even with load asserted
    reset = 1'b0; bus.load = 1'b1;
    applyStimulus();
    checkOutput("mrst_state", 64'(bus.state), 64'(IDLE));
    checkOutput("mrst_grid", bus.grid, 64'h0);
    checkOutput("mrst_gen", 64'(bus.generation), 64'd0);
    checkOutput("mrst_flags", {61'd0, bus.evolved, bus.stable, bus.extinct}, 64'd0);
    reset = 1'b1; bus.load = 1'b0;
    applyStimulus();
    checkOutput("post_rst_state", 64'(bus.state), 64'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
